// File: rtl/lc3_ctrl_fsm.sv
// LC-3 microsequencer: fetch/decode/execute for ADD, AND, NOT, LEA, LD, ST, BR, JSR.
// Every output is combinational from the state and inputs, and is forced to 0 while in reset.
module lc3_ctrl_fsm #(
  parameter int WAIT_LIMIT = 0,
  parameter int WAIT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ready,
  output logic        load_reg,
  output logic        dr_mux,
  output logic        sr1_mux,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_cc,
  output logic [2:0]  gate_sel,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_mux,
  output logic [1:0]  addr2_sel,
  output logic        mdr_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH0 = 4'd0, FETCH1 = 4'd1, FETCH2 = 4'd2, DECODE = 4'd3,
    ALU    = 4'd4, LEA    = 4'd5, LD0    = 4'd6, LD1    = 4'd7,
    LD2    = 4'd8, ST0    = 4'd9, ST1    = 4'd10, ST2   = 4'd11,
    BR     = 4'd12, JSR   = 4'd13
  } st_t;

  typedef struct packed {
    logic       load_reg, dr_mux, sr1_mux, ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc;
    logic [2:0] gate_sel;
    logic [1:0] alu_op, pc_mux, addr2_sel;
    logic       mdr_sel, mem_en, mem_we, illegal, bus_err;
  } ctl_t;

  st_t              cur, nxt;
  ctl_t             c, o;
  logic [WAIT_W-1:0] cnt;
  logic             wait_st, timeout, taken;
  logic [3:0]       op;

  assign op      = ir[15:12];
  assign wait_st = (cur == FETCH1) || (cur == LD1) || (cur == ST2);
  assign timeout = wait_st && (WAIT_LIMIT != 0) && (cnt == WAIT_W'(WAIT_LIMIT)) && !mem_ready;
  assign taken   = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  // Counter restarts on every entry into a wait state, since entry always changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH0;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= (wait_st && nxt == cur) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    nxt = FETCH0;
    case (cur)
      FETCH0: nxt = FETCH1;
      FETCH1: nxt = timeout ? FETCH0 : (mem_ready ? FETCH2 : FETCH1);
      FETCH2: nxt = DECODE;
      DECODE: begin
        case (op)
          4'b0000:                   nxt = BR;
          4'b0001, 4'b0101, 4'b1001: nxt = ALU;
          4'b0010:                   nxt = LD0;
          4'b0011:                   nxt = ST0;
          4'b0100:                   nxt = ir[11] ? JSR : FETCH0;
          4'b1110:                   nxt = LEA;
          default:                   nxt = FETCH0;
        endcase
      end
      LD0:     nxt = LD1;
      LD1:     nxt = timeout ? FETCH0 : (mem_ready ? LD2 : LD1);
      ST0:     nxt = ST1;
      ST1:     nxt = ST2;
      ST2:     nxt = (timeout || mem_ready) ? FETCH0 : ST2;
      default: nxt = FETCH0;
    endcase
  end

  always_comb begin
    c = '0;
    case (cur)
      FETCH0: begin c.gate_sel = 3'd1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
      FETCH1, LD1: begin c.mem_en = !timeout; c.ld_mdr = mem_ready; end
      FETCH2: begin c.gate_sel = 3'd2; c.ld_ir = 1'b1; end
      DECODE: c.illegal = !(op inside {4'b0000, 4'b0001, 4'b0101, 4'b1001,
                                       4'b0010, 4'b0011, 4'b1110} ||
                            (op == 4'b0100 && ir[11]));
      ALU: begin
        c.gate_sel = 3'd3; c.sr1_mux = 1'b1; c.load_reg = 1'b1; c.ld_cc = 1'b1;
        c.alu_op = (op == 4'b0101) ? 2'd1 : (op == 4'b1001) ? 2'd2 : 2'd0;
      end
      LEA: begin c.gate_sel = 3'd4; c.addr2_sel = 2'd2; c.load_reg = 1'b1; end
      LD0, ST0: begin c.gate_sel = 3'd4; c.addr2_sel = 2'd2; c.ld_mar = 1'b1; end
      LD2: begin c.gate_sel = 3'd2; c.load_reg = 1'b1; c.ld_cc = 1'b1; end
      ST1: begin
        c.gate_sel = 3'd3; c.alu_op = 2'd3; c.mdr_sel = 1'b1; c.ld_mdr = 1'b1;
      end
      ST2: begin c.mem_en = !timeout; c.mem_we = !timeout; end
      BR: if (taken) begin c.ld_pc = 1'b1; c.pc_mux = 2'd1; c.addr2_sel = 2'd2; end
      JSR: begin
        c.gate_sel = 3'd1; c.load_reg = 1'b1; c.dr_mux = 1'b1;
        c.ld_pc = 1'b1; c.pc_mux = 2'd1; c.addr2_sel = 2'd3;
      end
      default: c = '0;
    endcase
    c.bus_err = timeout;
  end

  assign o         = rst_n ? c : '0;
  assign load_reg  = o.load_reg;
  assign dr_mux    = o.dr_mux;
  assign sr1_mux   = o.sr1_mux;
  assign ld_mar    = o.ld_mar;
  assign ld_mdr    = o.ld_mdr;
  assign ld_ir     = o.ld_ir;
  assign ld_pc     = o.ld_pc;
  assign ld_cc     = o.ld_cc;
  assign gate_sel  = o.gate_sel;
  assign alu_op    = o.alu_op;
  assign pc_mux    = o.pc_mux;
  assign addr2_sel = o.addr2_sel;
  assign mdr_sel   = o.mdr_sel;
  assign mem_en    = o.mem_en;
  assign mem_we    = o.mem_we;
  assign illegal   = o.illegal;
  assign bus_err   = o.bus_err;
  assign state     = cur;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Scoreboard bench: an instruction-level model expands each instruction into expected
// per-cycle control words; a negedge monitor pops and compares them against the DUT.
module tb_lc3_ctrl_fsm;
  localparam int LIM = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       load_reg, dr_mux, sr1_mux, ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc;
    logic [2:0] gate_sel;
    logic [1:0] alu_op, pc_mux, addr2_sel;
    logic       mdr_sel, mem_en, mem_we, illegal, bus_err;
  } obs_t;

  logic clk = 0, rst_n = 0;
  logic [15:0] ir = 16'h1242;
  logic n = 1, z = 1, p = 1, mem_ready = 1;
  logic load_reg, dr_mux, sr1_mux, ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc;
  logic [2:0] gate_sel;
  logic [1:0] alu_op, pc_mux, addr2_sel;
  logic mdr_sel, mem_en, mem_we, illegal, bus_err;
  logic [3:0] state;
  obs_t obs;

  int checks = 0, failures = 0;
  obs_t exp_q[$];
  logic drv_q[$];

  always #5 clk = ~clk;

  lc3_ctrl_fsm #(.WAIT_LIMIT(LIM), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .n(n), .z(z), .p(p), .mem_ready(mem_ready),
    .load_reg(load_reg), .dr_mux(dr_mux), .sr1_mux(sr1_mux), .ld_mar(ld_mar),
    .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_cc(ld_cc), .gate_sel(gate_sel),
    .alu_op(alu_op), .pc_mux(pc_mux), .addr2_sel(addr2_sel), .mdr_sel(mdr_sel),
    .mem_en(mem_en), .mem_we(mem_we), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  assign obs = {state, load_reg, dr_mux, sr1_mux, ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc,
                gate_sel, alu_op, pc_mux, addr2_sel, mdr_sel, mem_en, mem_we, illegal, bus_err};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      automatic obs_t e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL seq ir=%h got=%h exp=%h (state got %0d exp %0d)", ir, obs, e, obs.st, e.st);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic obs_t rz(input logic [3:0] s);
    obs_t r = '0;
    r.st = s;
    return r;
  endfunction

  task automatic push(input obs_t r, input logic mr);
    exp_q.push_back(r);
    drv_q.push_back(mr);
  endtask

  // Memory access: ready arrives after d idle cycles; more than LIM idle cycles aborts.
  task automatic mem_phase(input obs_t base, input int d, input bit rd, output bit ok);
    obs_t r;
    ok = 0;
    for (int k = 0; k <= LIM; k++) begin
      if (k == d) begin
        r = base;
        if (rd) r.ld_mdr = 1;
        push(r, 1);
        ok = 1;
        return;
      end else if (k == LIM) begin
        r = rz(base.st);
        r.bus_err = 1;
        push(r, 0);
        return;
      end else push(base, 0);
    end
  endtask

  task automatic run_instr(input logic [15:0] i, input logic fn, fz, fp, input int fd, md);
    obs_t r;
    bit ok;
    ir = i; n = fn; z = fz; p = fp;
    r = rz(0); r.gate_sel = 1; r.ld_mar = 1; r.ld_pc = 1; push(r, 1'($urandom_range(0, 1)));
    r = rz(1); r.mem_en = 1; mem_phase(r, fd, 1, ok);
    if (ok) begin
      r = rz(2); r.gate_sel = 2; r.ld_ir = 1; push(r, 1'($urandom_range(0, 1)));
      r = rz(3);
      case (i[15:12])
        4'h0: begin
          push(r, 1'($urandom_range(0, 1)));
          r = rz(12);
          if ((i[11] && fn) || (i[10] && fz) || (i[9] && fp)) begin
            r.ld_pc = 1; r.pc_mux = 1; r.addr2_sel = 2;
          end
          push(r, 1'($urandom_range(0, 1)));
        end
        4'h1, 4'h5, 4'h9: begin
          push(r, 1'($urandom_range(0, 1)));
          r = rz(4); r.gate_sel = 3; r.sr1_mux = 1; r.load_reg = 1; r.ld_cc = 1;
          r.alu_op = (i[15:12] == 4'h1) ? 2'd0 : (i[15:12] == 4'h5) ? 2'd1 : 2'd2;
          push(r, 1'($urandom_range(0, 1)));
        end
        4'h2: begin
          push(r, 1'($urandom_range(0, 1)));
          r = rz(6); r.gate_sel = 4; r.addr2_sel = 2; r.ld_mar = 1; push(r, 1'($urandom_range(0, 1)));
          r = rz(7); r.mem_en = 1; mem_phase(r, md, 1, ok);
          if (ok) begin
            r = rz(8); r.gate_sel = 2; r.load_reg = 1; r.ld_cc = 1; push(r, 1'($urandom_range(0, 1)));
          end
        end
        4'h3: begin
          push(r, 1'($urandom_range(0, 1)));
          r = rz(9); r.gate_sel = 4; r.addr2_sel = 2; r.ld_mar = 1; push(r, 1'($urandom_range(0, 1)));
          r = rz(10); r.gate_sel = 3; r.alu_op = 3; r.mdr_sel = 1; r.ld_mdr = 1;
          push(r, 1'($urandom_range(0, 1)));
          r = rz(11); r.mem_en = 1; r.mem_we = 1; mem_phase(r, md, 0, ok);
        end
        4'hE: begin
          push(r, 1'($urandom_range(0, 1)));
          r = rz(5); r.gate_sel = 4; r.addr2_sel = 2; r.load_reg = 1; push(r, 1'($urandom_range(0, 1)));
        end
        default: begin
          if (i[15:12] == 4'h4 && i[11]) begin
            push(r, 1'($urandom_range(0, 1)));
            r = rz(13); r.gate_sel = 1; r.load_reg = 1; r.dr_mux = 1;
            r.ld_pc = 1; r.pc_mux = 1; r.addr2_sel = 3;
            push(r, 1'($urandom_range(0, 1)));
          end else begin
            r.illegal = 1;
            push(r, 1'($urandom_range(0, 1)));
          end
        end
      endcase
    end
    while (drv_q.size() > 0) begin
      mem_ready = drv_q.pop_front();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops[9];
    logic [15:0] ri;
    ops = '{4'h0, 4'h1, 4'h5, 4'h9, 4'h2, 4'h3, 4'h4, 4'hE, 4'hF};
    ir = 16'h4810;
    @(negedge clk);
    chk("reset_outputs", 32'(obs), 32'h0);
    @(posedge clk); #1 rst_n = 1;

    run_instr(16'h1242, 0, 0, 0, 0, 0);
    run_instr(16'h2405, 0, 0, 0, 0, 3);
    run_instr(16'h3602, 0, 0, 0, 1, 2);
    run_instr(16'h0A03, 0, 1, 0, 0, 0);
    run_instr(16'h0A03, 0, 0, 1, 0, 0);
    run_instr(16'h0003, 1, 1, 1, 0, 0);
    run_instr(16'h4810, 0, 0, 0, 0, 0);
    run_instr(16'hF025, 0, 0, 0, 0, 0);
    run_instr(16'h4000, 0, 0, 0, 0, 0);
    run_instr(16'h5283, 0, 0, 0, 2, 0);
    run_instr(16'h927F, 0, 0, 0, 0, 0);
    run_instr(16'hE1FF, 0, 0, 0, 0, 0);
    run_instr(16'h1242, 0, 0, 0, 9, 0);      // fetch timeout
    run_instr(16'h2405, 0, 0, 0, 0, LIM);    // ready on the limit cycle: no error
    run_instr(16'h2405, 0, 0, 0, 0, 7);      // load timeout
    run_instr(16'h3602, 0, 0, 0, 0, 8);      // store timeout

    // Reset in the middle of a fetch wait
    ir = 16'h1242; mem_ready = 0;
    @(posedge clk); #1;
    chk("mid_fetch_mem_en", 32'(mem_en), 32'h1);
    chk("mid_fetch_state", 32'(state), 32'h1);
    #2 rst_n = 0;
    #1;
    chk("rst_drop_mem_en", 32'(mem_en), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    @(posedge clk); #1 rst_n = 1;

    for (int t = 0; t < 300; t++) begin
      ri = 16'($urandom);
      ri[15:12] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) ri[15:12] = 4'($urandom);
      run_instr(ri, 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, LIM));
    end

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
